// File: rtl/char_fifo_if.sv
// Handshake and status bundle between a character producer/consumer and char_fifo.
// master drives push/pop controls; slave (the FIFO) drives data and status.
interface char_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              auto_mode;
    logic              ovf_clr;
    logic [DATA_W-1:0] rd_data;
    logic              not_empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport master (
        output wr_en, wr_data, rd_en, auto_mode, ovf_clr,
        input  rd_data, not_empty, full, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, auto_mode, ovf_clr,
        output rd_data, not_empty, full, count, overflow
    );
endinterface

// File: rtl/char_fifo.sv
// First-word-fall-through character FIFO with sticky overflow status.
// Define CHAR_FIFO_PACE_EN to build the paced auto-drain (auto_mode) logic.
module char_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int PACE   = 5
) (
    input  logic        clk,
    input  logic        rst,
    char_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              pop_req, pop, push, drop;
    logic              full, not_empty;

`ifdef CHAR_FIFO_PACE_EN
    logic [7:0] pace_q, pace_d;
    logic       pace_tick;

    always_comb begin
        pace_tick = (pace_q == 8'(PACE - 1));
        pace_d    = pace_tick ? 8'd0 : pace_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) pace_q <= 8'd0;
        else     pace_q <= pace_d;
    end

    assign pop_req = bus.auto_mode ? pace_tick : bus.rd_en;
`else
    // auto_mode and PACE have no effect without the pacing logic
    logic unused_pace;
    assign unused_pace = ^{bus.auto_mode, 8'(PACE)};
    assign pop_req     = bus.rd_en;
`endif

    always_comb begin
        full      = (cnt_q == CNT_FULL);
        not_empty = (cnt_q != '0);
        pop       = not_empty & pop_req;
        // a full FIFO still accepts a push when it pops in the same cycle
        push      = bus.wr_en & (~full | pop);
        drop      = bus.wr_en & full & ~pop;
        wptr_d    = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d    = pop ? rptr_q + PTR_ONE : rptr_q;
        cnt_d     = cnt_q;
        if (push & ~pop)      cnt_d = cnt_q + CNT_ONE;
        else if (pop & ~push) cnt_d = cnt_q - CNT_ONE;
        ovf_d     = drop | (ovf_q & ~bus.ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push & ~rst) mem_q[wptr_q] <= bus.wr_data;
    end

    assign bus.rd_data   = not_empty ? mem_q[rptr_q] : '0;
    assign bus.not_empty = not_empty;
    assign bus.full      = full;
    assign bus.count     = cnt_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_char_fifo.sv
// Randomized and directed bench for char_fifo against a queue-based model.
// Pacing expectations follow CHAR_FIFO_PACE_EN as compiled.
module tb_char_fifo;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int PACE   = 5;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef CHAR_FIFO_PACE_EN
    localparam bit PACE_EN = 1'b1;
`else
    localparam bit PACE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    char_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    char_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PACE(PACE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mq[$];
    bit  m_ovf   = 1'b0;
    int  m_cyc   = 0;
    bit  armed   = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int exp_rd;
        exp_rd = (mq.size() != 0) ? int'(mq[0]) : 0;
        check("rd_data",   int'(bus.rd_data),   exp_rd);
        check("not_empty", int'(bus.not_empty), int'(mq.size() != 0));
        check("full",      int'(bus.full),      int'(mq.size() == DEPTH));
        check("count",     int'(bus.count),     mq.size());
        check("overflow",  int'(bus.overflow),  int'(m_ovf));
    endtask

    // Model: pace counter is just cycles-since-reset modulo PACE
    task automatic model_step(input bit wr, input logic [DATA_W-1:0] d,
                              input bit rd, input bit am, input bit clr,
                              input bit r);
        bit tick, preq, pop, fl, push, drop;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cyc = 0;
            return;
        end
        tick = PACE_EN && ((m_cyc % PACE) == PACE - 1);
        preq = (PACE_EN && am) ? tick : rd;
        pop  = (mq.size() != 0) && preq;
        fl   = (mq.size() == DEPTH);
        push = wr && (!fl || pop);
        drop = wr && fl && !pop;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_cyc++;
    endtask

    task automatic cyc(input bit wr, input logic [DATA_W-1:0] d,
                       input bit rd, input bit am, input bit clr,
                       input bit r);
        @(negedge clk);
        if (armed) check_all();
        bus.wr_en     = wr;
        bus.wr_data   = d;
        bus.rd_en     = rd;
        bus.auto_mode = am;
        bus.ovf_clr   = clr;
        rst           = r;
        @(posedge clk);
        model_step(wr, d, rd, am, clr, r);
        if (r) armed = 1'b1;
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_data = '0; bus.rd_en = 0;
        bus.auto_mode = 0; bus.ovf_clr = 0;
        // reset, then pops on an empty FIFO
        cyc(1, 8'h77, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);
        // fill with 'A'..'H'
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h41 + i), 0, 0, 0, 0);
        // dropped 'I' with a simultaneous clear: set wins
        cyc(1, 8'h49, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 8'h49, 0, 0, 0, 0);
        // push+pop while full
        cyc(1, 8'h5A, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0, 0, 0);
        // push+pop while empty
        cyc(1, 8'h5A, 1, 0, 0, 0);
        // 20 push/pop pairs walk the pointers around twice
        for (int i = 0; i < 20; i++) cyc(1, 8'(i * 7 + 3), 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        // paced drain after reset
        cyc(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h31 + i), 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, 0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit wr, rd, am, clr, r;
            wr  = ($urandom_range(99) < 55);
            rd  = ($urandom_range(99) < 45);
            am  = ($urandom_range(99) < 30);
            clr = ($urandom_range(99) < 5);
            r   = ($urandom_range(999) < 4);
            cyc(wr, 8'($urandom), rd, am, clr, r);
        end
        @(negedge clk);
        check_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/char_fifo.md
# char_fifo

Parametrised character FIFO between the PS/2 keyboard scan-to-ASCII decoder and the consumers of typed characters: the VGA text-console writer and the CPU keyboard I/O port. It generalises the fixed 8-deep, 8-bit, paced ASCII buffer:
- configurable data width and depth;
- explicit pop handshake or paced auto-drain, selectable at run time;
- full, occupancy and sticky-overflow status.

## Interface
Parameters:
- DATA_W, 8, character/data width in bits
- ADDR_W, 3, pointer width; depth DEPTH = 2^ADDR_W entries
- PACE, 5, auto-drain period in clk cycles (legal range 1..255)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- wr_en  input  1  push request, one entry per cycle asserted
- wr_data  input  DATA_W  data pushed when wr_en accepted
- rd_en  input  1  pop request, used when auto_mode=0
- auto_mode  input  1  1: entries drain automatically, one per PACE cycles; 0: drain on rd_en only
- ovf_clr  input  1  clears overflow
- rd_data  output  DATA_W  head entry (first-word-fall-through); 0 when empty
- not_empty  output  1  FIFO holds at least one entry
- full  output  1  count == DEPTH
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a push was dropped because the FIFO was full

## Operation
- State registers:
  - wptr, rptr: ADDR_W bits, wrap modulo DEPTH.
  - cnt: ADDR_W+1 bits.
  - pace_cnt: 8 bits.
  - ovf: 1 bit.
  - mem: DEPTH x DATA_W, not reset.
- pace_cnt free-runs 0..PACE-1 and wraps to 0. pace_tick = (pace_cnt == PACE-1). pace_cnt runs regardless of auto_mode or occupancy.
- pop = not_empty & (auto_mode ? pace_tick : rd_en). rd_en while empty is ignored; no underflow flag.
- push = wr_en & (~full | pop). A push into a full FIFO is accepted only when a pop occurs in the same cycle.
- On push: mem[wptr] <= wr_data; wptr <= wptr+1.
- On pop: rptr <= rptr+1.
- cnt update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Dropped write (wr_en & full & ~pop): data discarded, pointers unchanged, ovf <= 1.
- ovf_clr clears ovf to 0. If a drop occurs in the same cycle, set wins and ovf stays 1.
- Outputs:
  - not_empty = (cnt != 0)
  - full = (cnt == DEPTH)
  - count = cnt
  - overflow = ovf
  - rd_data = not_empty ? mem[rptr] : 0
- Switching auto_mode mid-stream takes effect the same cycle. Stored entries are never lost or reordered.

## Timing
- Reset (rst=1 at a rising edge): wptr=rptr=0, cnt=0, pace_cnt=0, ovf=0. Outputs after reset: rd_data=0, not_empty=0, full=0, count=0, overflow=0.
- Reset mid-operation empties the FIFO in one cycle. Contents are logically discarded. A wr_en in the reset cycle is ignored.
- Write latency: data pushed at edge N appears on rd_data with not_empty=1 after edge N (one cycle).
- Pop: rd_data shows the next entry, or 0 if now empty, immediately after the popping edge.
- Auto-drain throughput: at most one pop per PACE cycles. The first pop after reset happens at the edge where pace_cnt = PACE-1, i.e. cycle PACE.
- Push and pop on the same edge while empty: the push is accepted, the pop is not; cnt becomes 1.
- Push and pop on the same edge while full: both happen; cnt stays DEPTH; ovf unchanged.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no special handling. Full and empty are distinguished by cnt only.

## Configuration
- CHAR_FIFO_PACE_EN defined: pace_cnt and auto-drain logic built; auto_mode behaves as above.
- CHAR_FIFO_PACE_EN undefined: pace_cnt removed and auto_mode ignored; pop = not_empty & rd_en. The PACE parameter is unused.

## Test plan
Defaults unless stated (DATA_W=8, ADDR_W=3, PACE=5).
- Reset/empty: rst held 1, then released; rd_en pulsed with no writes -> rd_data=0, not_empty=0, count=0 throughout; rptr unchanged.
- Fill and overflow, auto_mode=0, rd_en=0:
  - push 'A'..'H' (0x41..0x48) -> full=1 and count=8 after the 8th edge, rd_data=0x41.
  - 9th push 'I' -> dropped, overflow=1, count=8.
  - pop 8 times -> rd_data sequence 0x41..0x48, then rd_data=0, not_empty=0.
- Simultaneous push/pop:
  - while full, wr_en=1 and rd_en=1 with 0x5A -> count stays 8, overflow unchanged, 0x5A emerges 8th.
  - while empty, same stimulus -> count=1, rd_data=0x5A.
- Auto-drain (macro defined, auto_mode=1): push 3 bytes at cycles 1..3 after reset -> pops at edges where pace_cnt=4, spaced exactly 5 cycles apart; not_empty falls after the 3rd pop.
- Overflow clear priority: ovf_clr=1 in the same cycle as a dropped write -> overflow=1. ovf_clr=1 alone -> overflow=0 the next cycle.
- Wrap/reset mid-run: 20 push/pop pairs to cycle pointers twice; data order is preserved. Then assert rst with count=5 -> count=0, not_empty=0 the next cycle.
